shot_clock_display: RTL

//  Output stage for the 24-second shot-clock counter. Consumes the counter's BCD

---
 rtl/shot_clock_display.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/shot_clock_display.sv
// rtl/shot_clock_display.sv - shot-clock output stage: multiplexed 2-digit 7-seg scan and alarm beeper
module shot_clock_display #(
  parameter int SCAN_DIV   = 4,
  parameter int BEEP_ON    = 8,
  parameter int BEEP_OFF   = 8,
  parameter int BEEP_COUNT = 3
) (
  input  logic       cp,
  input  logic       rest,
  input  logic [3:0] timerH,
  input  logic [3:0] timerL,
  input  logic       alarm,
  output logic [6:0] seg,
  output logic [1:0] dig,
  output logic       buzzer,
  output logic       busy
);

  localparam int DIV_W   = $clog2(SCAN_DIV);
  localparam int CNT_MAX = (BEEP_ON > BEEP_OFF) ? BEEP_ON : BEEP_OFF;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int N_W     = $clog2(BEEP_COUNT + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(BEEP_ON - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(BEEP_OFF - 1);
  localparam logic [N_W-1:0]   N_LAST   = N_W'(BEEP_COUNT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF} beep_t;

  logic [3:0]       h_q, l_q;
  logic             alarm_q, alarm_d;
  logic [DIV_W-1:0] div;
  logic             sel;
  logic             wrap, sel_n;
  logic [3:0]       shown;
  logic [6:0]       seg_n;
  beep_t            state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [N_W-1:0]   n, n_n;

  function automatic logic [6:0] dec7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  always_ff @(posedge cp or posedge rest) begin
    if (rest) begin
      h_q     <= 4'd0;
      l_q     <= 4'd0;
      alarm_q <= 1'b0;
      alarm_d <= 1'b0;
    end else begin
      h_q     <= timerH;
      l_q     <= timerL;
      alarm_q <= alarm;
      alarm_d <= alarm_q;
    end
  end

  // The new digit's segments load on the same edge as its enable, so the slot is never stale.
  assign wrap  = (div == DIV_LAST);
  assign sel_n = wrap ? ~sel : sel;

  always_comb begin
    shown = sel_n ? h_q : l_q;
    seg_n = (sel_n && (h_q == 4'd0)) ? 7'h00 : dec7(shown);
  end

  always_ff @(posedge cp or posedge rest) begin
    if (rest) begin
      div <= '0;
      sel <= 1'b0;
      dig <= 2'b00;
      seg <= 7'h00;
    end else begin
      div <= wrap ? '0 : div + 1'b1;
      sel <= sel_n;
      if (wrap) begin
        dig <= sel_n ? 2'b10 : 2'b01;
        seg <= seg_n;
      end else if (dig != 2'b00) begin
        seg <= seg_n;
      end
    end
  end

  always_ff @(posedge cp or posedge rest) begin
    if (rest) begin
      state <= ST_IDLE;
      cnt   <= '0;
      n     <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      n     <= n_n;
    end
  end

  // Dropping alarm aborts the pattern; only a fresh rising edge restarts it.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    n_n     = n;
    case (state)
      ST_IDLE: begin
        if (alarm_q && !alarm_d) begin
          state_n = ST_ON;
          cnt_n   = '0;
          n_n     = '0;
        end
      end
      ST_ON: begin
        if (!alarm_q) begin
          state_n = ST_IDLE;
        end else if (cnt == ON_LAST) begin
          cnt_n   = '0;
          state_n = (n < N_LAST) ? ST_OFF : ST_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_OFF: begin
        if (!alarm_q) begin
          state_n = ST_IDLE;
        end else if (cnt == OFF_LAST) begin
          cnt_n   = '0;
          n_n     = n + 1'b1;
          state_n = ST_ON;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    buzzer = (state == ST_ON);
    busy   = (state != ST_IDLE);
  end

endmodule
